ucode_datapath: RTL and testbench
=================================

// Module: ucode_datapath
// PURPOSE
//   Datapath core for the uCode CPU: one registered ALU and one LIFO stack block.
//   The CPU uses two stacks, data (D) and return (R), by instantiating two ucode_datapath copies.
//   It wires the ALU arguments from its own sequencer, typically from top-of-stack d0/d1.
//   All state is clocked on i_clk; i_rst clears both the stack and the ALU result.
// PARAMETERS
//   WIDTH  16  bits per stack cell, ALU operand and ALU result
//   DEPTH  16  LIFO capacity in cells; must be >= 2 and a power of 2
// PORTS
//   i_clk    in   1      system clock, rising edge
//   i_rst    in   1      reset, asynchronous, active-high
//   i_data   in   WIDTH  value to push
//   i_push   in   1      push i_data (single-cycle strobe)
//   i_pop    in   1      pop top of stack (single-cycle strobe)
//   o_s0     out  WIDTH  top-of-stack cell (TOS)
//   o_s1     out  WIDTH  next-on-stack cell (NOS)
//   o_empty  out  1      stack holds 0 cells
//   o_full   out  1      stack holds DEPTH cells
//   i_op     in   4      ALU operation code (see ucode_pkg)
//   i_arg0   in   WIDTH  ALU first operand
//   i_arg1   in   WIDTH  ALU second operand
//   o_data   out  WIDTH  ALU result register
// BEHAVIOUR
//   Reset (async, i_rst=1):
//     - Stack count is cleared to 0 and all cells are cleared.
//     - Outputs go to o_s0=0, o_s1=0, o_empty=1, o_full=0, o_data=0.
//     - Reset asserted mid-operation discards any push/pop/op in that cycle.
//   LIFO:
//     - o_s0 and o_s1 always reflect the current registers, with no read latency.
//     - Push only: after the next edge, o_s0=i_data and o_s1=old o_s0; count+1.
//     - Pop only: after the next edge, o_s0=old o_s1 and o_s1=old third cell; count-1.
//     - Push and pop together: TOS is replaced by i_data; o_s1 and count are unchanged.
//     - Underflow: pop when empty leaves count at 0 and cells at 0.
//     - Reading below the stored cells: o_s0/o_s1 read 0 when fewer than 1/2 cells are stored.
//     - Overflow: push when full discards the bottom cell; count stays DEPTH.
//   ALU:
//     - 1-cycle latency: o_data is registered from i_op/i_arg0/i_arg1 at each rising edge.
//     - All arithmetic is modulo 2^WIDTH; no carry or flags are produced.
//     - Op encoding (hex):
//         0 NO_OP (o_data holds its value)   1 ADD a0+a1       2 SUB a0-a1
//         3 AND a0&a1                        4 OR  a0|a1       5 XOR a0^a1
//         6 ROL {a0[W-2:0],a0[W-1]}          7 INC a0+1        8 DEC a0-1
//         9 NOT ~a0                          A NEG -a0         B MUL (optional)
//     - Ops C-F are reserved and behave as NO_OP.
// CONFIGURATION
//   UCODE_ALU_MUL_EN defined:
//     - Op B is MUL: o_data = low WIDTH bits of a0*a1.
//   UCODE_ALU_MUL_EN undefined:
//     - Op B behaves as NO_OP and no multiplier is synthesised.
// STRUCTURE
//   Package ucode_pkg:
//     - Holds the ALU op codes as `define/localparam names: NO_OP, ADD, SUB, AND, OR,
//       XOR, ROL, INC, DEC, NOT, NEG, MUL.
//     - The CPU decoder imports the same package.
//   Sub-module ucode_stack:
//     - Holds the LIFO: cell array, count, TOS/NOS muxing and the o_empty/o_full flags.
//     - The ALU case statement stays inline in ucode_datapath.
// TESTING
//   1 Reset:
//     - Pulse i_rst between clock edges, then check o_s0=0, o_s1=0, o_empty=1, o_data=0
//       before any clock edge.
//   2 Push/pop order:
//     - Push 0x1111 then 0x2222: expect s0=0x2222, s1=0x1111.
//     - Pop: expect s0=0x1111, s1=0.
//     - Pop: expect o_empty=1.
//   3 Replace and underflow:
//     - Push 0x00AA, then push+pop 0x00BB together: expect s0=0x00BB and count unchanged.
//     - Pop twice more: expect s0=0, o_empty=1, no X values.
//   4 Overflow:
//     - Push 1..DEPTH+1: expect o_full=1, s0=DEPTH+1, s1=DEPTH.
//     - Then pop DEPTH times: expect the last popped value to be 2 (cell 1 discarded).
//   5 ALU ops:
//     - ADD 0xFFFF+0x0001 -> 0x0000.
//     - SUB 0x0003-0x0005 -> 0xFFFE.
//     - ROL 0x8001 -> 0x0003.
//     - NEG 0x0001 -> 0xFFFF.
//     - XOR 0xF0F0^0xFFFF -> 0x0F0F.
//     - Each result appears one cycle after the op is applied.
//   6 NO_OP and MUL:
//     - NO_OP holds the previous o_data.
//     - MUL 0x0102*0x0003 -> 0x0306 with UCODE_ALU_MUL_EN, else o_data unchanged.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared ALU op codes for the uCode datapath and the CPU decoder.
// Op B (MUL) is only live when the datapath is built with UCODE_ALU_MUL_EN.
package ucode_pkg;

  localparam int OP_W = 4;

  // Codes C-F are reserved and decode as NO_OP in the datapath.
  typedef enum logic [OP_W-1:0] {
    NO_OP = 4'h0,
    ADD   = 4'h1,
    SUB   = 4'h2,
    AND   = 4'h3,
    OR    = 4'h4,
    XOR   = 4'h5,
    ROL   = 4'h6,
    INC   = 4'h7,
    DEC   = 4'h8,
    NOT   = 4'h9,
    NEG   = 4'hA,
    MUL   = 4'hB
  } alu_op_e;

  function automatic logic [15:0] rol1_16(input logic [15:0] a);
    return {a[14:0], a[15]};
  endfunction

endpackage

// File: rtl/ucode_stack.sv
// LIFO with zero-latency TOS/NOS outputs, built as a shift register (cell 0 = TOS).
// Overflow drops the bottom cell; underflow is a no-op on the count.
module ucode_stack
  import ucode_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] s0_o,
  output logic [WIDTH-1:0] s1_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] cells_q [DEPTH];
  logic [WIDTH-1:0] cells_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  always_comb begin
    cells_d = cells_q;
    count_d = count_q;
    if (push_i && pop_i) begin
      cells_d[0] = data_i;
    end else if (push_i) begin
      for (int i = 1; i < DEPTH; i++) cells_d[i] = cells_q[i-1];
      cells_d[0] = data_i;
      if (count_q != FULL_CNT) count_d = count_q + CW'(1);
    end else if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) cells_d[i] = cells_q[i+1];
      cells_d[DEPTH-1] = '0;
      if (count_q != '0) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) cells_q[i] <= '0;
      count_q <= '0;
    end else begin
      cells_q <= cells_d;
      count_q <= count_d;
    end
  end

  // Cells past the stored count may hold stale data, so reads there are forced to 0.
  assign s0_o    = (count_q != '0)     ? cells_q[0] : '0;
  assign s1_o    = (count_q > CW'(1))  ? cells_q[1] : '0;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/ucode_datapath.sv
// uCode CPU datapath slice: one LIFO stack plus a registered single-cycle ALU.
// Define UCODE_ALU_MUL_EN to make op B a multiply; otherwise op B holds o_data.
module ucode_datapath
  import ucode_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1,
  output logic             o_empty,
  output logic             o_full,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  ucode_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .data_i (i_data),
    .push_i (i_push),
    .pop_i  (i_pop),
    .s0_o   (o_s0),
    .s1_o   (o_s1),
    .empty_o(o_empty),
    .full_o (o_full)
  );

  always_comb begin
    data_d = data_q;
    case (i_op)
      ADD:     data_d = i_arg0 + i_arg1;
      SUB:     data_d = i_arg0 - i_arg1;
      AND:     data_d = i_arg0 & i_arg1;
      OR:      data_d = i_arg0 | i_arg1;
      XOR:     data_d = i_arg0 ^ i_arg1;
      ROL:     data_d = {i_arg0[WIDTH-2:0], i_arg0[WIDTH-1]};
      INC:     data_d = i_arg0 + WIDTH'(1);
      DEC:     data_d = i_arg0 - WIDTH'(1);
      NOT:     data_d = ~i_arg0;
      NEG:     data_d = -i_arg0;
`ifdef UCODE_ALU_MUL_EN
      MUL:     data_d = i_arg0 * i_arg1;
`endif
      default: data_d = data_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) data_q <= '0;
    else       data_q <= data_d;
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_ucode_datapath.sv
// Directed bench for ucode_datapath: stack order, replace/underflow, overflow, ALU ops.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ucode_datapath;
  import ucode_pkg::*;

  localparam int W = 16;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  data = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  s0, s1, alu_q;
  logic          empty, full;
  logic [3:0]    op = 4'h0;
  logic [W-1:0]  a0 = '0;
  logic [W-1:0]  a1 = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_data;

  always #5 clk = ~clk;

  ucode_datapath #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_push (push),
    .i_pop  (pop),
    .o_s0   (s0),
    .o_s1   (s1),
    .o_empty(empty),
    .o_full (full),
    .i_op   (op),
    .i_arg0 (a0),
    .i_arg1 (a1),
    .o_data (alu_q)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic stk(input logic ps, input logic pp, input logic [W-1:0] v);
    push = ps;
    pop  = pp;
    data = v;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] exp);
    op = o;
    a0 = x;
    a1 = y;
    #1 check_eq({tag, "_pre"}, 32'(alu_q), 32'(exp_data));
    @(negedge clk);
    check_eq(tag, 32'(alu_q), 32'(exp));
    exp_data = exp;
    op = 4'h0;
  endtask

  initial begin
    // 1 reset between edges
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("rst_s0", 32'(s0), 32'h0);
    check_eq("rst_s1", 32'(s1), 32'h0);
    check_eq("rst_empty", 32'(empty), 32'h1);
    check_eq("rst_full", 32'(full), 32'h0);
    check_eq("rst_data", 32'(alu_q), 32'h0);
    exp_data = '0;
    @(negedge clk);

    // 2 push/pop order
    stk(1'b1, 1'b0, 16'h1111);
    stk(1'b1, 1'b0, 16'h2222);
    check_eq("push2_s0", 32'(s0), 32'h2222);
    check_eq("push2_s1", 32'(s1), 32'h1111);
    check_eq("push2_empty", 32'(empty), 32'h0);
    stk(1'b0, 1'b1, '0);
    check_eq("pop1_s0", 32'(s0), 32'h1111);
    check_eq("pop1_s1", 32'(s1), 32'h0);
    stk(1'b0, 1'b1, '0);
    check_eq("pop2_empty", 32'(empty), 32'h1);
    check_eq("pop2_s0", 32'(s0), 32'h0);

    // 3 replace and underflow
    stk(1'b1, 1'b0, 16'h00AA);
    stk(1'b1, 1'b1, 16'h00BB);
    check_eq("repl_s0", 32'(s0), 32'h00BB);
    check_eq("repl_s1", 32'(s1), 32'h0);
    check_eq("repl_empty", 32'(empty), 32'h0);
    stk(1'b0, 1'b1, '0);
    check_eq("under1_empty", 32'(empty), 32'h1);
    stk(1'b0, 1'b1, '0);
    check_eq("under2_s0", 32'(s0), 32'h0);
    check_eq("under2_s1", 32'(s1), 32'h0);
    check_eq("under2_empty", 32'(empty), 32'h1);
    check_eq("under2_full", 32'(full), 32'h0);
    stk(1'b1, 1'b0, 16'h0055);
    check_eq("after_under_s0", 32'(s0), 32'h0055);
    check_eq("after_under_s1", 32'(s1), 32'h0);
    stk(1'b0, 1'b1, '0);

    // 4 overflow
    for (int i = 1; i <= D + 1; i++) begin
      stk(1'b1, 1'b0, W'(i));
      if (i == D) check_eq("full_at_depth", 32'(full), 32'h1);
    end
    check_eq("ovf_full", 32'(full), 32'h1);
    check_eq("ovf_s0", 32'(s0), 32'(D + 1));
    check_eq("ovf_s1", 32'(s1), 32'(D));
    for (int i = 1; i < D; i++) stk(1'b0, 1'b1, '0);
    check_eq("ovf_last_s0", 32'(s0), 32'h2);
    check_eq("ovf_last_s1", 32'(s1), 32'h0);
    stk(1'b0, 1'b1, '0);
    check_eq("ovf_drained", 32'(empty), 32'h1);

    // 5 ALU ops
    alu("add", ADD, 16'hFFFF, 16'h0001, 16'h0000);
    alu("add2", ADD, 16'h1234, 16'h1111, 16'h2345);
    alu("sub", SUB, 16'h0003, 16'h0005, 16'hFFFE);
    alu("rol", ROL, 16'h8001, 16'h0000, 16'h0003);
    alu("neg", NEG, 16'h0001, 16'h0000, 16'hFFFF);
    alu("xor", XOR, 16'hF0F0, 16'hFFFF, 16'h0F0F);
    alu("and", AND, 16'h0FF0, 16'h3C3C, 16'h0C30);
    alu("or", OR, 16'h0F00, 16'h00F0, 16'h0FF0);
    alu("inc", INC, 16'hFFFF, 16'h0000, 16'h0000);
    alu("dec", DEC, 16'h0000, 16'h0000, 16'hFFFF);
    alu("not", NOT, 16'h1234, 16'h0000, 16'hEDCB);

    // 6 NO_OP, reserved, MUL
    alu("noop", NO_OP, 16'h5555, 16'h3333, 16'hEDCB);
    alu("rsvd_c", 4'hC, 16'h5555, 16'h3333, 16'hEDCB);
    alu("rsvd_f", 4'hF, 16'h5555, 16'h3333, 16'hEDCB);
`ifdef UCODE_ALU_MUL_EN
    alu("mul", MUL, 16'h0102, 16'h0003, 16'h0306);
`else
    alu("mul_off", MUL, 16'h0102, 16'h0003, 16'hEDCB);
`endif

    // reset mid-operation clears ALU and stack
    stk(1'b1, 1'b0, 16'h7777);
    op = ADD; a0 = 16'h0001; a1 = 16'h0001; push = 1'b1; data = 16'h8888;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    push = 1'b0; op = 4'h0;
    check_eq("midrst_data", 32'(alu_q), 32'h0);
    check_eq("midrst_empty", 32'(empty), 32'h1);
    check_eq("midrst_s0", 32'(s0), 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
